storage_port_arbiter: RTL
=========================

Name: storage_port_arbiter

Overview:
- Shares the single read/write port of matrix storage among four requesters:
  - UART parser writes (index 0)
  - random generator writes (1)
  - operand loader reads (2)
  - display formatter reads (3)
- Round-robin grant with burst lock, so one matrix (up to 25 elements) transfers without interleaving.
- Sits between the requesters and matrix storage in the top level. Replaces the ad-hoc start_gen/start_input data muxing.

Parameters:
- NUM_REQ, 4, number of requesters.
- ADDR_W, 9, storage address width ({matrix_id[3:0], elem_idx[4:0]}).
- DATA_W, 8, element width.
- MAX_BURST, 25, maximum accesses per grant (5x5 matrix).
- IDLE_TIMEOUT, 64, cycles an owner may hold the grant with no access before forced release.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req  in  NUM_REQ  per-requester bus request; level, held for the whole burst
- acc_en  in  NUM_REQ  per-requester access strobe, one access per cycle
- acc_we  in  NUM_REQ  1=write, 0=read, qualified by acc_en
- acc_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- acc_wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot grant, registered
- rdata  out  DATA_W  read data broadcast to all requesters
- rvalid  out  NUM_REQ  one-hot, read data valid for requester i
- mem_en  out  1  storage access enable
- mem_we  out  1  storage write enable
- mem_addr  out  ADDR_W  storage address
- mem_wdata  out  DATA_W  storage write data
- mem_rdata  in  DATA_W  storage read data, valid 1 cycle after mem_en&&!mem_we
- busy  out  1  a grant is active or draining
- err_illegal  out  1  1-cycle pulse: acc_en from a non-owner
- err_timeout  out  1  1-cycle pulse: owner forcibly released

Behaviour:
- Reset values:
  - gnt=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0
  - busy=0, err_illegal=0, err_timeout=0
  - rr pointer=0, burst count=0, idle count=0, state=IDLE
- FSM states are IDLE, GRANT and DRAIN.
- IDLE:
  - If any req is set, pick the first requester with req set, starting at the rr pointer and wrapping modulo NUM_REQ.
  - gnt goes one-hot on the next edge and the state moves to GRANT (request-to-grant latency 1 cycle).
  - With no req, stay in IDLE.
- GRANT:
  - Owner access is forwarded combinationally to mem_* when gnt[i]&&acc_en[i]. Otherwise mem_en=0.
  - Each forwarded access increments the burst count and clears the idle count. A cycle with no access increments the idle count.
  - Move to DRAIN and clear gnt on the next edge when any of these holds:
    - req[owner] falls
    - the burst count reaches MAX_BURST (the MAX_BURST-th access is still forwarded)
    - the idle count reaches IDLE_TIMEOUT; also pulse err_timeout
- DRAIN:
  - Lasts exactly one cycle, so an outstanding read returns. rvalid may assert here.
  - Set rr pointer = owner+1 (mod NUM_REQ), clear counters, return to IDLE.
  - Minimum gap between grants is 1 idle cycle.
- Read return:
  - A forwarded read registers the owner index.
  - Next cycle rdata=mem_rdata, rvalid[owner]=1.
  - Back-to-back reads give one rvalid per cycle.
- Simultaneous events:
  - acc_en in the same cycle req[owner] falls: the access is honoured, then DRAIN.
  - Timeout and burst limit in the same cycle: release once, err_timeout pulses.
- Non-owner acc_en: ignored, no storage effect, err_illegal pulses the next cycle.
- An owner acc_en while in IDLE or DRAIN is ignored with no error.
- Reset mid-burst: all state returns to reset values on that edge. A pending rvalid is suppressed.
- busy=1 in GRANT and DRAIN.

Optional Feature:
- Macro: STORAGE_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, lowest index wins; the rr pointer stays 0 and is not updated. Writers are favoured over readers.
- When undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- matrix_pkg holds:
  - arb_state_t (IDLE/GRANT/DRAIN)
  - MAX_ELEMS=25, MATRIX_ID_W=4, ELEM_IDX_W=5
  - requester index constants REQ_PARSER=0, REQ_RAND=1, REQ_LOAD=2, REQ_FMT=3
- One natural sub-module is rr_pick: combinational rotating priority encoder (req, pointer) -> one-hot pick plus valid.
- FSM, counters and read-return tracking stay in the top.

Test Plan:
- Single requester: req[1]=1 for 25 writes, addr 0x20..0x38 -> gnt=0010 one cycle after req; 25 mem writes with matching addr/data; after the 25th, DRAIN then IDLE; busy low 2 cycles after the last write.
- Contention: req=1111 held continuously -> grant order 0,1,2,3,0 (round-robin), each burst capped at 25; with FIXED_PRIO_EN, requester 0 regrants every time.
- Reads: requester 2 reads addr 0x40..0x44 back-to-back with mem_rdata=addr[7:0] -> rvalid[2] one cycle after each read; rdata 0x40..0x44 in order, including the last one in DRAIN.
- Illegal and timeout: owner 3 idles 64 cycles with req high while requester 0 pulses acc_en -> err_illegal pulse with no mem write; err_timeout pulse at idle count 64; gnt cleared.
- Edge case: acc_en and req fall together on the 5th access -> the 5th access is performed, then DRAIN.
- Reset: rst asserted mid-burst with a read pending -> next cycle all outputs are 0, no rvalid, and the next grant starts from requester 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix storage port and its requesters.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_ELEMS   = 25;
    localparam int unsigned MATRIX_ID_W = 4;
    localparam int unsigned ELEM_IDX_W  = 5;

    localparam int unsigned REQ_PARSER = 0;
    localparam int unsigned REQ_RAND   = 1;
    localparam int unsigned REQ_LOAD   = 2;
    localparam int unsigned REQ_FMT    = 3;

endpackage

// File: rtl/storage_port_arbiter_if.sv
// Requester-side and storage-side signals of the shared matrix storage port.
interface storage_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        acc_en;
    logic [NUM_REQ-1:0]        acc_we;
    logic [NUM_REQ*ADDR_W-1:0] acc_addr;
    logic [NUM_REQ*DATA_W-1:0] acc_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         rdata;
    logic [NUM_REQ-1:0]        rvalid;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    // Requesters plus storage model.
    modport master (
        output req, acc_en, acc_we, acc_addr, acc_wdata, mem_rdata,
        input  gnt, rdata, rvalid, mem_en, mem_we, mem_addr, mem_wdata
    );

    // The arbiter.
    modport slave (
        input  req, acc_en, acc_we, acc_addr, acc_wdata, mem_rdata,
        output gnt, rdata, rvalid, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/storage_port_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr_i, wrapping around.
module storage_port_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IDX_W-1:0]   pick_idx_o,
    output logic               valid_o
);

    always_comb begin
        logic        found;
        int unsigned j;
        pick_o     = '0;
        pick_idx_o = '0;
        found      = 1'b0;
        j          = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[j]) begin
                found      = 1'b1;
                pick_o[j]  = 1'b1;
                pick_idx_o = IDX_W'(j);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/storage_port_arbiter.sv
// Round-robin, burst-locked arbiter for the single matrix storage port.
// Define STORAGE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module storage_port_arbiter
    import matrix_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ADDR_W       = MATRIX_ID_W + ELEM_IDX_W,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MAX_BURST    = MAX_ELEMS,
    parameter int unsigned IDLE_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    storage_port_arbiter_if.slave bus,
    output logic                  busy,
    output logic                  err_illegal,
    output logic                  err_timeout
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam int unsigned TMO_W = $clog2(IDLE_TIMEOUT + 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   burst_q, burst_d;
    logic [TMO_W-1:0]   idle_q, idle_d;
    logic               rd_pend_q, rd_pend_d;
    logic [IDX_W-1:0]   rd_owner_q, rd_owner_d;
    logic               err_illegal_q, err_illegal_d;
    logic               err_timeout_q, err_timeout_d;

    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [NUM_REQ-1:0] owner_mask;
    logic               owner_en;
    logic               illegal;

    storage_port_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i      (bus.req),
        .ptr_i      (rr_ptr_q),
        .pick_o     (pick),
        .pick_idx_o (pick_idx),
        .valid_o    (pick_valid)
    );

    assign owner_mask = NUM_REQ'(1) << owner_q;
    // gnt_q is zero outside GRANT, so owner strobes in IDLE/DRAIN are dropped here.
    assign owner_en   = |(gnt_q & bus.acc_en);
    assign illegal    = (state_q != IDLE) && |(bus.acc_en & ~owner_mask);

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (owner_en) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.acc_we[owner_q];
            bus.mem_addr  = bus.acc_addr[32'(owner_q) * ADDR_W +: ADDR_W];
            bus.mem_wdata = bus.acc_wdata[32'(owner_q) * DATA_W +: DATA_W];
        end
    end

    always_comb begin
        logic hit_burst;
        logic hit_idle;
        logic dropped;
        state_d       = state_q;
        gnt_d         = gnt_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        burst_d       = burst_q;
        idle_d        = idle_q;
        rd_pend_d     = owner_en && !bus.acc_we[owner_q];
        rd_owner_d    = owner_q;
        err_illegal_d = illegal;
        err_timeout_d = 1'b0;
        hit_burst     = 1'b0;
        hit_idle      = 1'b0;
        dropped       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    gnt_d   = pick;
                    owner_d = pick_idx;
                    burst_d = '0;
                    idle_d  = '0;
                end
            end
            GRANT: begin
                burst_d   = burst_q + CNT_W'(owner_en);
                idle_d    = owner_en ? '0 : idle_q + TMO_W'(1);
                hit_burst = (burst_d == CNT_W'(MAX_BURST));
                hit_idle  = (idle_d == TMO_W'(IDLE_TIMEOUT));
                dropped   = !bus.req[owner_q];
                if (hit_burst || hit_idle || dropped) begin
                    state_d       = DRAIN;
                    gnt_d         = '0;
                    err_timeout_d = hit_idle;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                burst_d = '0;
                idle_d  = '0;
`ifdef STORAGE_ARB_FIXED_PRIO_EN
                rr_ptr_d = '0;
`else
                rr_ptr_d = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IDX_W'(1);
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            burst_q       <= '0;
            idle_q        <= '0;
            rd_pend_q     <= 1'b0;
            rd_owner_q    <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            burst_q       <= burst_d;
            idle_q        <= idle_d;
            rd_pend_q     <= rd_pend_d;
            rd_owner_q    <= rd_owner_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Storage returns read data one cycle after the access, so route it straight through.
    assign bus.rdata  = rd_pend_q ? bus.mem_rdata : '0;
    assign bus.rvalid = rd_pend_q ? (NUM_REQ'(1) << rd_owner_q) : '0;
    assign bus.gnt    = gnt_q;

    assign busy        = (state_q != IDLE);
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;

endmodule
